aes_key_expand: RTL and testbench
=================================

Name: aes_key_expand

Overview:
- Iterative AES key-schedule engine; generates one 128-bit round key per clock.
- Feeds decipher_key_mem directly through a write strobe, write index, key data and round count.
- Also feeds the encrypt datapath, which samples round keys as they are written.
- Supports AES-128 (10 rounds) and AES-256 (14 rounds); the 256-bit path is a compile option.

Parameters:
- KEY_W, 256, width of the key_in port; a 128-bit key occupies the upper half.
- RK_W, 128, round-key width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to expand key_in; ignored while busy.
- key_256  input  1  1 = AES-256, 0 = AES-128; sampled with start.
- key_in  input  256  cipher key, big-endian. AES-128 uses [255:128]; [127:0] is ignored.
- round_key_out  output  128  round key being written this cycle.
- write_round  output  4  index of round_key_out (0..round_amount).
- dec_key_gen  output  1  write strobe into decipher_key_mem.
- round_amount  output  4  10 or 14; held stable from start until the next start.
- busy  output  1  expansion in progress.
- done  output  1  one-cycle pulse after the final write.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, key window cleared.
- Reset while in EXPAND aborts the expansion. No further strobes; the partial memory contents are don't-care.
- FSM states and transitions:
  - IDLE: on start, capture key_in into a 256-bit window {A,B} (A = upper 128 bits), set round_amount, go to EXPAND with round counter r = 0.
  - EXPAND, every cycle:
    - Drive dec_key_gen = 1, write_round = r, round_key_out = key(r).
    - Increment r.
    - When r == round_amount, go to FIN.
  - FIN: done = 1 for one cycle, busy = 0 next cycle, return to IDLE.
- Latency:
  - start sampled at cycle 0; round k is written at cycle k+1.
  - Last write is at cycle Nr+1; done pulses at cycle Nr+2.
  - busy = 1 from cycle 1 through cycle Nr+1.
- Round-key generation:
  - key(0) = A.
  - AES-128: key(r) for r ≥ 1 is
    - t = SubWord(RotWord(prev.w3)) ^ Rcon[r]
    - w0 = prev.w0 ^ t, then w_i = prev.w_i ^ w_(i-1)
  - AES-256: key(1) = B. For r ≥ 2:
    - even r: t = SubWord(RotWord(B.w3)) ^ Rcon[r/2]
    - odd r: t = SubWord(B.w3)
    - w0 = A.w0 ^ t, then w_i = A.w_i ^ w_(i-1)
    - Window shifts: A <= B, B <= new.
  - Rcon is in the high byte of the word: 01,02,04,08,10,20,40,80,1b,36.
  - Key computation is registered, so round_key_out is a flop output with no combinational path from key_in.
- Boundary conditions:
  - start while busy or in FIN: ignored; key_in and key_256 are not recaptured.
  - start in the same cycle FIN returns to IDLE: ignored; a start is accepted only in IDLE.
  - write_round never exceeds round_amount.
  - dec_key_gen is never asserted outside EXPAND.

Optional Feature:
- Macro: AES_KEY_EXPAND_256_EN.
- Defined:
  - AES-256 path present: window register B, odd/even round selection, round_amount 14.
- Undefined:
  - key_256 is ignored and treated as 0; round_amount is always 10.
  - key_in[127:0] is unused, and the B register and 256-bit logic are not synthesised.
  - Port list is unchanged.

Decomposition:
- Shared package aes_pkg holds:
  - the FSM state enum {IDLE, EXPAND, FIN};
  - constants NR_128 = 10 and NR_256 = 14;
  - the RCON array[1:10];
  - a typedef for the 32-bit word.
- One sub-module, aes_sub_word: 32-bit SubWord built from four combinational S-box lookups.
  - It reuses the existing forward S-box function/table.
  - It is instantiated once, since only one word per round needs substitution.

Test Plan:
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c:
  - write_round 0 at cycle 1 carries the key itself.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at cycle 11.
  - done at cycle 12; exactly 11 strobes.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - Round 1 = 1f352c073b6108d72d9810a30914dff4.
  - Round 14 = fe4890d1e6188d0b046df344706c631e at cycle 15.
  - round_amount = 14; 15 strobes.
- Re-pulse start at cycles 3 and 12 during the AES-128 run: outputs identical to a single run; no extra strobes.
- Deassert rst_n at cycle 5:
  - All outputs drop to 0 asynchronously, before the next clock edge.
  - After release, a new start produces the full correct sequence.
- Build without AES_KEY_EXPAND_256_EN, key_256 = 1 with the AES-128 vector: identical to the AES-128 result, round_amount = 10.
- Back-to-back runs, start at the first IDLE cycle after done: second run results are correct and independent of the first.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-expansion FSM states, round counts, Rcon table,
// 32-bit word type and the forward S-box used by SubWord.
package aes_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {IDLE, EXPAND, FIN} aes_state_e;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_256 = 4'd14;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Out-of-range indices occur on the cycle after the last round; result is unused there.
  function automatic logic [7:0] rcon_at(input logic [3:0] i);
    if (i >= 4'd1 && i <= 4'd10) return RCON[i];
    return 8'h00;
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-expansion request/round-key bus: master issues start/key, slave streams round keys.
interface aes_key_expand_if #(
  parameter int KEY_W = 256,
  parameter int RK_W  = 128
);
  logic             start;
  logic             key_256;
  logic [KEY_W-1:0] key_in;
  logic [RK_W-1:0]  round_key_out;
  logic [3:0]       write_round;
  logic             dec_key_gen;
  logic [3:0]       round_amount;
  logic             busy;
  logic             done;

  modport master (
    output start, key_256, key_in,
    input  round_key_out, write_round, dec_key_gen, round_amount, busy, done
  );

  modport slave (
    input  start, key_256, key_in,
    output round_key_out, write_round, dec_key_gen, round_amount, busy, done
  );
endinterface

// File: rtl/aes_sub_word.sv
// SubWord: four parallel forward S-box lookups on a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  word_t in_w,
  output word_t out_w
);
  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign out_w[8*i +: 8] = sbox(in_w[8*i +: 8]);
  end
endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES key schedule, one registered round key per clock into decipher_key_mem.
// AES-256 support is compiled in only when AES_KEY_EXPAND_256_EN is defined.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int KEY_W = 256,
  parameter int RK_W  = 128
) (
  input logic             clk,
  input logic             rst_n,
  aes_key_expand_if.slave kx
);

  aes_state_e      state_q, state_d;
  logic [RK_W-1:0] win_a_q, win_a_d, rk_q, rk_d, next_key;
  logic [3:0]      rnd_q, rnd_d, nr_q, nr_d, next_r;
  logic            dec_q, dec_d, busy_q, busy_d, done_q, done_d;
  logic            req_256;
  word_t           sub_in, sub_out, t_w, w0, w1, w2, w3;
  logic [7:0]      rc;

  assign next_r = rnd_q + 4'd1;

`ifdef AES_KEY_EXPAND_256_EN
  logic [RK_W-1:0] win_b_q, win_b_d;
  logic            is_256;

  assign is_256  = (nr_q == NR_256);
  assign req_256 = kx.key_256;

  // AES-256 alternates: even rounds get RotWord+Rcon, odd rounds plain SubWord, both on B.w3.
  always_comb begin
    sub_in = rot_word(win_a_q[31:0]);
    rc     = rcon_at(next_r);
    if (is_256) begin
      sub_in = next_r[0] ? win_b_q[31:0] : rot_word(win_b_q[31:0]);
      rc     = next_r[0] ? 8'h00 : rcon_at({1'b0, next_r[3:1]});
    end
  end
`else
  logic unused_in;
  assign unused_in = ^{kx.key_256, kx.key_in[KEY_W-RK_W-1:0]};
  assign req_256   = 1'b0;
  assign sub_in    = rot_word(win_a_q[31:0]);
  assign rc        = rcon_at(next_r);
`endif

  aes_sub_word u_sub (.in_w(sub_in), .out_w(sub_out));

  assign t_w      = sub_out ^ {rc, 24'h0};
  assign w0       = win_a_q[127:96] ^ t_w;
  assign w1       = win_a_q[95:64]  ^ w0;
  assign w2       = win_a_q[63:32]  ^ w1;
  assign w3       = win_a_q[31:0]   ^ w2;
  assign next_key = {w0, w1, w2, w3};

  always_comb begin
    state_d = state_q;
    win_a_d = win_a_q;
    rk_d    = rk_q;
    rnd_d   = rnd_q;
    nr_d    = nr_q;
    dec_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef AES_KEY_EXPAND_256_EN
    win_b_d = win_b_q;
`endif
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (kx.start) begin
          state_d = EXPAND;
          nr_d    = req_256 ? NR_256 : NR_128;
          win_a_d = kx.key_in[KEY_W-1 -: RK_W];
`ifdef AES_KEY_EXPAND_256_EN
          win_b_d = kx.key_in[RK_W-1:0];
`endif
          rk_d    = kx.key_in[KEY_W-1 -: RK_W];
          rnd_d   = 4'd0;
          dec_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      EXPAND: begin
        if (rnd_q == nr_q) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          dec_d   = 1'b1;
          rnd_d   = next_r;
          rk_d    = next_key;
          win_a_d = next_key;
`ifdef AES_KEY_EXPAND_256_EN
          // Round 1 is the key's lower half; afterwards the {A,B} window slides by one key.
          if (is_256) begin
            if (rnd_q == 4'd0) begin
              rk_d    = win_b_q;
              win_a_d = win_a_q;
            end else begin
              win_a_d = win_b_q;
              win_b_d = next_key;
            end
          end
`endif
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_a_q <= '0;
      rk_q    <= '0;
      rnd_q   <= '0;
      nr_q    <= '0;
      dec_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_a_q <= win_a_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
      nr_q    <= nr_d;
      dec_q   <= dec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef AES_KEY_EXPAND_256_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) win_b_q <= '0;
    else        win_b_q <= win_b_d;
  end
`endif

  assign kx.round_key_out = rk_q;
  assign kx.write_round   = rnd_q;
  assign kx.dec_key_gen   = dec_q;
  assign kx.round_amount  = nr_q;
  assign kx.busy          = busy_q;
  assign kx.done          = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: driver queues expected round keys from a
// word-array key schedule (S-box derived from GF(2^8) inverses); a monitor compares strobes.
module tb_aes_key_expand;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0, n_vec = 0, n_err = 0, done_cnt = 0, strobes = 0;

  logic [7:0]   sb [0:255];
  logic [7:0]   rc [0:10];
  logic [127:0] mdl_rk [0:14];
  int           mdl_nr;
  logic [127:0] cap [0:15];

  typedef struct { logic [127:0] key; int rnd; int nr; int cyc; } exp_t;
  typedef struct { int n; int cyc; } done_t;
  exp_t  exp_q [$];
  done_t done_q [$];

  localparam logic [127:0] K128    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R1_128  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [255:0] K256    = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R1_256  = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

  aes_key_expand_if #(.KEY_W(256), .RK_W(128)) kx ();
  aes_key_expand #(.KEY_W(256), .RK_W(128)) dut (.clk(clk), .rst_n(rst_n), .kx(kx));

  always #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int i = 2; i <= 10; i++) rc[i] = gmul(rc[i-1], 8'h02);
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic model(input logic [255:0] key, input bit is256);
    logic [31:0] w [0:59];
    logic [31:0] t;
    int nk;
    nk = is256 ? 8 : 4;
    mdl_nr = is256 ? 14 : 10;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(mdl_nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc[i/nk], 24'h0};
      else if (nk == 8 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= mdl_nr; r++) mdl_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_rk"},    kx.round_key_out,        128'h0);
    chk({tag, "_wr"},    128'(kx.write_round),    128'h0);
    chk({tag, "_strb"},  128'(kx.dec_key_gen),    128'h0);
    chk({tag, "_namt"},  128'(kx.round_amount),   128'h0);
    chk({tag, "_busy"},  128'(kx.busy),           128'h0);
    chk({tag, "_done"},  128'(kx.done),           128'h0);
  endtask

  // Issue one start in IDLE, optionally re-pulse start (with junk key) on cycles set in mask.
  task automatic run(input logic [255:0] key, input bit k256, input logic [31:0] mask);
    int base, d0;
    bit eff, got;
`ifdef AES_KEY_EXPAND_256_EN
    eff = k256;
`else
    eff = 1'b0;
`endif
    model(key, eff);
    @(posedge clk); #1;
    base = cyc;
    d0 = done_cnt;
    kx.start = 1'b1; kx.key_256 = k256; kx.key_in = key;
    for (int r = 0; r <= mdl_nr; r++)
      exp_q.push_back('{key: mdl_rk[r], rnd: r, nr: mdl_nr, cyc: base + 1 + r});
    done_q.push_back('{n: mdl_nr + 1, cyc: base + mdl_nr + 2});
    got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(posedge clk); #1;
      kx.key_in = {rnd128(), rnd128()};
      kx.key_256 = 1'($urandom_range(0, 1));
      kx.start = (c < 32) ? mask[c] : 1'b0;
      @(negedge clk); #1;
      if (done_cnt != d0) got = 1'b1;
    end
    if (kx.start) begin
      @(posedge clk); #1;
    end
    kx.start = 1'b0;
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: no done within 40 cycles of start at cycle %0d", base);
    end
  endtask

  // Monitor: every strobe and done is matched against the scoreboard queues.
  initial forever begin
    exp_t  e;
    done_t d;
    @(negedge clk);
    if (!rst_n) strobes = 0;
    else begin
      if (kx.dec_key_gen) begin
        strobes++;
        cap[kx.write_round] = kx.round_key_out;
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious_strobe: round %0d at cycle %0d, none expected", kx.write_round, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("round_key",    kx.round_key_out,       e.key);
          chk("write_round",  128'(kx.write_round),   128'(e.rnd));
          chk("round_amount", 128'(kx.round_amount),  128'(e.nr));
          chk("strobe_cycle", 128'(cyc),              128'(e.cyc));
          chk("busy_expand",  128'(kx.busy),          128'h1);
        end
      end
      if (kx.done) begin
        if (done_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious_done: cycle %0d, none expected", cyc);
        end else begin
          d = done_q.pop_front();
          chk("strobe_count", 128'(strobes), 128'(d.n));
          chk("done_cycle",   128'(cyc),     128'(d.cyc));
          chk("busy_at_done", 128'(kx.busy), 128'h0);
        end
        strobes = 0;
        done_cnt++;
      end
    end
  end

  initial begin
    int base;
    logic [255:0] k;
    bit k2;
    kx.start = 1'b0; kx.key_256 = 1'b0; kx.key_in = '0;
    build_tables();
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // AES-128 known answer, then an immediate back-to-back second run.
    run({K128, rnd128()}, 1'b0, 32'h0);
    chk("kat128_r0",  cap[0],  K128);
    chk("kat128_r1",  cap[1],  R1_128);
    chk("kat128_r10", cap[10], R10_128);
`ifdef AES_KEY_EXPAND_256_EN
    run(K256, 1'b1, 32'h0);
    chk("kat256_r1",  cap[1],  R1_256);
    chk("kat256_r14", cap[14], R14_256);
`else
    run({K128, rnd128()}, 1'b1, 32'h0);
    chk("no256_r10", cap[10], R10_128);
    chk("no256_namt", 128'(kx.round_amount), 128'd10);
`endif

    // Start re-pulsed at cycles 3 and 12 must be ignored.
    run({K128, rnd128()}, 1'b0, 32'h0000_1008);
    chk("repulse_r10", cap[10], R10_128);

    // Asynchronous reset in the middle of an expansion.
    model({K128, 128'h0}, 1'b0);
    @(posedge clk); #1;
    base = cyc;
    kx.start = 1'b1; kx.key_256 = 1'b0; kx.key_in = {K128, rnd128()};
    for (int r = 0; r < 4; r++)
      exp_q.push_back('{key: mdl_rk[r], rnd: r, nr: 10, cyc: base + 1 + r});
    @(posedge clk); #1 kx.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    chk("strobes_before_rst", 128'(exp_q.size()), 128'h0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    run({K128, rnd128()}, 1'b0, 32'h0);
    chk("post_rst_r10", cap[10], R10_128);

    // Randomised back-to-back runs with ignored start pulses mid-expansion.
    for (int i = 0; i < 8; i++) begin
      k  = {rnd128(), rnd128()};
      k2 = 1'($urandom_range(0, 1));
      run(k, k2, $urandom & 32'h0000_0FFE);
    end

    repeat (4) @(negedge clk);
    chk("leftover_rounds", 128'(exp_q.size()),  128'h0);
    chk("leftover_done",   128'(done_q.size()), 128'h0);
    chk("idle_busy",       128'(kx.busy),       128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
